// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   UART_DATA_W : width of one UART byte
//   MAX_N_REQ   : largest supported requester count
//   IDX_W       : width of a requester index (sized for MAX_N_REQ)
//   arb_state_t : arbiter FSM state encoding
//   rr_next     : round-robin successor of an index, wrapping at n
package uart_arb_pkg;

  localparam int UART_DATA_W = 8;
  localparam int MAX_N_REQ   = 4;
  localparam int IDX_W       = $clog2(MAX_N_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_t;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority picker, no state.
//   req    : request vector
//   ptr    : index with highest priority; search goes upward and wraps
//   onehot : one-hot winner (0 when no request)
//   idx    : winner index
//   any    : at least one request present
module rr_picker
  import uart_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any       = 1'b1;
        onehot[c] = 1'b1;
        idx       = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit channel between N_REQ byte
// sources. The granted byte is registered and held until the UART accepts it.
// Build option: define UART_ARB_LOCK_EN to keep the grant with one requester
// for a whole message (ended by REQ_last, capped at MAX_BURST bytes or
// HOLD_TIMEOUT idle cycles).
//   CLK, RESET      : clock, synchronous active-high reset
//   REQ_valid/data  : per-requester byte offer, byte i in bits [8i+7:8i]
//   REQ_last        : byte ends the requester's message (lock build only)
//   REQ_ack         : combinational accept per requester
//   UART_TX/_valid  : registered byte to the UART
//   UART_TX_ready   : UART accepts the byte at this edge
//   GRANT           : registered one-hot owner, 0 in IDLE
//
// state | meaning
// IDLE  | no byte held; pick a winner from REQ_valid starting at ptr
// SEND  | byte held on UART_TX until UART_TX_ready
// HOLD  | lock build: owner keeps grant between bytes of one message
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 64
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [N_REQ-1:0]             REQ_valid,
  input  logic [UART_DATA_W*N_REQ-1:0] REQ_data,
  input  logic [N_REQ-1:0]             REQ_last,
  output logic [N_REQ-1:0]             REQ_ack,
  output logic [UART_DATA_W-1:0]       UART_TX,
  output logic                         UART_TX_valid,
  input  logic                         UART_TX_ready,
  output logic [N_REQ-1:0]             GRANT
);

  arb_state_t              state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        owner;
  logic [N_REQ-1:0]        pick_onehot;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [IDX_W-1:0]        sel_idx;
  logic [UART_DATA_W-1:0]  sel_data;

  rr_picker #(.N(N_REQ)) u_picker (
    .req    (REQ_valid),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // In IDLE the byte comes from the winner, in HOLD from the current owner.
  assign sel_idx = (state == ST_IDLE) ? pick_idx : owner;

`ifdef UART_ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [BW-1:0] MAX_BURST_C    = BW'(MAX_BURST);
  localparam logic [IW-1:0] HOLD_TIMEOUT_C = IW'(HOLD_TIMEOUT);

  logic          sel_last;
  logic          last_q;
  logic [BW-1:0] burst_cnt;
  logic [IW-1:0] idle_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^{REQ_last, 32'(MAX_BURST), 32'(HOLD_TIMEOUT)};
`endif

  always_comb begin
    sel_data = '0;
`ifdef UART_ARB_LOCK_EN
    sel_last = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_data = REQ_data[i*UART_DATA_W +: UART_DATA_W];
`ifdef UART_ARB_LOCK_EN
        sel_last = REQ_last[i];
`endif
      end
    end
  end

  always_comb begin
    REQ_ack = '0;
    if (state == ST_IDLE) REQ_ack = pick_onehot;
`ifdef UART_ARB_LOCK_EN
    else if (state == ST_HOLD) REQ_ack = GRANT & REQ_valid;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      owner         <= '0;
      GRANT         <= '0;
      UART_TX       <= '0;
      UART_TX_valid <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      last_q        <= 1'b0;
      burst_cnt     <= '0;
      idle_cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            UART_TX       <= sel_data;
            UART_TX_valid <= 1'b1;
            GRANT         <= pick_onehot;
            owner         <= pick_idx;
            state         <= ST_SEND;
`ifdef UART_ARB_LOCK_EN
            last_q        <= sel_last;
            burst_cnt     <= BW'(1);
            idle_cnt      <= '0;
`endif
          end
        end

        ST_SEND: begin
          if (UART_TX_ready) begin
            UART_TX_valid <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            if (!last_q && (burst_cnt < MAX_BURST_C)) begin
              state    <= ST_HOLD;
              idle_cnt <= '0;
            end else
`endif
            begin
              ptr   <= rr_next(owner, N_REQ);
              GRANT <= '0;
              state <= ST_IDLE;
            end
          end
        end

`ifdef UART_ARB_LOCK_EN
        ST_HOLD: begin
          if (|(GRANT & REQ_valid)) begin
            UART_TX       <= sel_data;
            UART_TX_valid <= 1'b1;
            last_q        <= sel_last;
            idle_cnt      <= '0;
            state         <= ST_SEND;
            if (burst_cnt != '1) burst_cnt <= burst_cnt + 1'b1;
          end else if (idle_cnt >= HOLD_TIMEOUT_C - 1'b1) begin
            // This cycle is the HOLD_TIMEOUT-th idle one: give up the grant.
            idle_cnt <= '0;
            ptr      <= rr_next(owner, N_REQ);
            GRANT    <= '0;
            state    <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
`endif

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [N-1:0]  REQ_valid;
  logic [8*N-1:0] REQ_data;
  logic [N-1:0]  REQ_last;
  logic [N-1:0]  REQ_ack;
  logic [7:0]    UART_TX;
  logic          UART_TX_valid;
  logic          UART_TX_ready;
  logic [N-1:0]  GRANT;

  int n_assert = 0;
  int n_fail   = 0;

  // Requester byte queues, expected and observed UART streams.
  logic [7:0] dq0[$], dq1[$];
  logic       lq0[$], lq1[$];
  logic [7:0] exp_q[$], got_q[$];

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(16), .HOLD_TIMEOUT(64)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .REQ_valid     (REQ_valid),
    .REQ_data      (REQ_data),
    .REQ_last      (REQ_last),
    .REQ_ack       (REQ_ack),
    .UART_TX       (UART_TX),
    .UART_TX_valid (UART_TX_valid),
    .UART_TX_ready (UART_TX_ready),
    .GRANT         (GRANT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic reset_dut();
    RESET = 1'b1;
    REQ_valid = '0;
    REQ_data = '0;
    REQ_last = '1;
    UART_TX_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic drive_heads();
    REQ_valid[0]   = dq0.size() > 0;
    REQ_data[7:0]  = (dq0.size() > 0) ? dq0[0] : 8'h00;
    REQ_last[0]    = (lq0.size() > 0) ? lq0[0] : 1'b1;
    REQ_valid[1]   = dq1.size() > 0;
    REQ_data[15:8] = (dq1.size() > 0) ? dq1[0] : 8'h00;
    REQ_last[1]    = (lq1.size() > 0) ? lq1[0] : 1'b1;
  endtask

  // Requesters present queue heads, pop on ack; UART bytes collected on accept.
  task automatic run_queues(input int budget, input bit rnd_ready);
    logic [N-1:0] ack_s;
    logic         acc_s, held;
    logic [7:0]   byte_s, held_byte;
    int           cyc;
    held = 1'b0;
    held_byte = 8'h00;
    cyc = 0;
    got_q.delete();
    while (got_q.size() < exp_q.size() && cyc < budget) begin
      drive_heads();
      UART_TX_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      ack_s = REQ_ack;
      check("ack_onehot", 32'($countones(ack_s) <= 1), 32'd1);
      check("ack_without_valid", 32'(ack_s & ~REQ_valid), 32'd0);
      if (held) check("tx_stable", 32'(UART_TX), 32'(held_byte));
      held      = UART_TX_valid && !UART_TX_ready;
      held_byte = UART_TX;
      acc_s     = UART_TX_valid && UART_TX_ready;
      byte_s    = UART_TX;
      @(posedge CLK);
      #1;
      if (ack_s[0] && dq0.size() > 0) begin void'(dq0.pop_front()); void'(lq0.pop_front()); end
      if (ack_s[1] && dq1.size() > 0) begin void'(dq1.pop_front()); void'(lq1.pop_front()); end
      if (acc_s) got_q.push_back(byte_s);
      cyc++;
    end
    check("run_budget", 32'(cyc < budget), 32'd1);
    REQ_valid = '0;
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [7:0] c0[$], c1[$];
    int p, w, ack_at;

    // Reset state
    reset_dut();
    check("rst_tx", 32'(UART_TX), 32'h0);
    check("rst_valid", 32'(UART_TX_valid), 32'h0);
    check("rst_grant", 32'(GRANT), 32'h0);
    check("rst_ack", 32'(REQ_ack), 32'h0);

    // Single byte from requester 0
    REQ_data = {8'h00, 8'h41};
    REQ_valid = 2'b01;
    UART_TX_ready = 1'b1;
    @(negedge CLK);
    check("single_ack", 32'(REQ_ack), 32'h1);
    @(posedge CLK); #1;
    REQ_valid = '0;
    check("single_tx", 32'(UART_TX), 32'h41);
    check("single_valid", 32'(UART_TX_valid), 32'h1);
    check("single_grant", 32'(GRANT), 32'h1);
    @(negedge CLK);
    check("single_ack_send", 32'(REQ_ack), 32'h0);
    @(posedge CLK); #1;
    check("single_done_valid", 32'(UART_TX_valid), 32'h0);
    check("single_done_grant", 32'(GRANT), 32'h0);

    // Backpressure: requester 1 holds 0x5A while ready is low; requester 0 waits
    UART_TX_ready = 1'b0;
    REQ_data = {8'h5A, 8'h11};
    REQ_valid = 2'b10;
    @(negedge CLK);
    check("bp_ack", 32'(REQ_ack), 32'h2);
    @(posedge CLK); #1;
    REQ_valid = 2'b01;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check("bp_tx", 32'(UART_TX), 32'h5A);
      check("bp_valid", 32'(UART_TX_valid), 32'h1);
      check("bp_ack_zero", 32'(REQ_ack), 32'h0);
      check("bp_grant", 32'(GRANT), 32'h2);
    end
    UART_TX_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_released", 32'(UART_TX_valid), 32'h0);
    check("bp_grant_clear", 32'(GRANT), 32'h0);
    @(negedge CLK);
    check("bp_next_ack", 32'(REQ_ack), 32'h1);
    @(posedge CLK); #1;
    REQ_valid = '0;
    check("bp_next_tx", 32'(UART_TX), 32'h11);
    @(posedge CLK); #1;
    check("bp_next_done", 32'(UART_TX_valid), 32'h0);

    // Reset while a byte is held
    UART_TX_ready = 1'b0;
    REQ_data = {8'h00, 8'h77};
    REQ_valid = 2'b01;
    @(posedge CLK); #1;
    REQ_valid = '0;
    check("rsend_pre_valid", 32'(UART_TX_valid), 32'h1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("rsend_valid", 32'(UART_TX_valid), 32'h0);
    check("rsend_grant", 32'(GRANT), 32'h0);
    check("rsend_tx", 32'(UART_TX), 32'h0);

    // Fairness after reset: both continuously valid, ready high
    REQ_data = {8'h31, 8'h30};
    REQ_valid = 2'b11;
    UART_TX_ready = 1'b1;
    @(negedge CLK);
    check("rsend_next_ack", 32'(REQ_ack), 32'h1);
    @(posedge CLK); #1;
    for (int k = 0; k < 8; k++) begin
      check("fair_valid", 32'(UART_TX_valid), 32'(k % 2 == 0));
      if (k % 2 == 0) begin
        check("fair_tx", 32'(UART_TX), (k % 4 == 0) ? 32'h30 : 32'h31);
        check("fair_grant", 32'(GRANT), (k % 4 == 0) ? 32'h1 : 32'h2);
      end
      @(posedge CLK); #1;
    end
    REQ_valid = '0;

    // Random: variable-length streams, random ready, every byte a message end
    reset_dut();
    dq0.delete(); dq1.delete(); lq0.delete(); lq1.delete();
    for (int i = 0; i < int'($urandom_range(3, 12)); i++) begin
      dq0.push_back(8'($urandom)); lq0.push_back(1'b1);
    end
    for (int i = 0; i < int'($urandom_range(3, 12)); i++) begin
      dq1.push_back(8'($urandom)); lq1.push_back(1'b1);
    end
    c0 = dq0; c1 = dq1; p = 0; exp_q.delete();
    while (c0.size() + c1.size() > 0) begin
      if (p == 0) w = (c0.size() > 0) ? 0 : 1;
      else        w = (c1.size() > 0) ? 1 : 0;
      if (w == 0) exp_q.push_back(c0.pop_front());
      else        exp_q.push_back(c1.pop_front());
      p = (w + 1) % N;
    end
    run_queues(2000, 1'b1);
    compare_stream("rand_stream");

`ifdef UART_ARB_LOCK_EN
    // Locked message "ABC" while requester 1 waits with 0x7E
    reset_dut();
    dq0 = '{8'h41, 8'h42, 8'h43}; lq0 = '{1'b0, 1'b0, 1'b1};
    dq1 = '{8'h7E};               lq1 = '{1'b1};
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h7E};
    run_queues(200, 1'b1);
    compare_stream("lock_abc");

    // Burst cap: 20 unterminated bytes, grant released after 16
    reset_dut();
    dq0.delete(); lq0.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) begin dq0.push_back(8'(8'h80 + i)); lq0.push_back(1'b0); end
    dq1 = '{8'h55}; lq1 = '{1'b1};
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h80 + i));
    exp_q.push_back(8'h55);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'h80 + i));
    run_queues(400, 1'b0);
    compare_stream("lock_burst");

    // Idle timeout: owner silent in HOLD, requester 1 gets ack after 64 idle cycles
    reset_dut();
    UART_TX_ready = 1'b1;
    REQ_data = {8'h00, 8'hA0};
    REQ_last = 2'b10;
    REQ_valid = 2'b01;
    @(posedge CLK); #1;
    REQ_valid = '0;
    @(posedge CLK); #1;
    check("lock_to_sent", 32'(UART_TX_valid), 32'h0);
    REQ_data = {8'h66, 8'h00};
    REQ_last = 2'b11;
    REQ_valid = 2'b10;
    ack_at = 0;
    for (int k = 1; k <= 100 && ack_at == 0; k++) begin
      @(negedge CLK);
      if (REQ_ack[1]) ack_at = k;
      @(posedge CLK); #1;
    end
    check("lock_timeout_cycle", 32'(ack_at), 32'd65);
    REQ_valid = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
